seg7_scan_driver: RTL and testbench
===================================

# seg7_scan_driver

Time-multiplexed, parametrised N-digit 7-segment display driver for the board's common-anode displays. Holds a shadow register of DIGITS 4-bit codes, scans one digit at a time with a blanking gap between digits, and decodes each code to active-low segments g~a. Codes 0-9 always decode; codes A-F decode when hex mode is enabled. Adds per-digit blanking, decimal points, leading-zero suppression and tear-free frame-synchronous updates. Sits between the datapath/counter logic and the board display pins.

## Interface
- DIGITS, 8: number of digits scanned, 2..8.
- SHOW_CYC, 50000: clocks each digit is driven, ≥1.
- GAP_CYC, 500: clocks all anodes are off between digits (anti-ghosting), ≥1.
- HEX_EN, 1: 1 = codes 10-15 show A,b,C,d,E,F; 0 = codes 10-15 blank.

- iClk  in  1  system clock; all state changes on rising edge.
- iRst_n  in  1  asynchronous active-low reset.
- iData  in  4*DIGITS  digit codes; bits [4k+3:4k] = digit k; digit 0 is least significant and rightmost.
- iDp  in  DIGITS  decimal point per digit, 1 = lit.
- iBlank  in  DIGITS  per-digit blank, 1 = digit dark.
- iLoad  in  1  1-cycle strobe: capture iData/iDp/iBlank.
- iLzs  in  1  leading-zero suppression enable, sampled live.
- oSeg  out  7  segments g~a (bit 6 = g, bit 0 = a), active-low.
- oDp  out  1  decimal point, active-low.
- oAn  out  DIGITS  digit enables, active-low, at most one low.
- oFrame  out  1  1-cycle pulse: new frame started, active set updated.

## Operation
- Registers: pending set (data/dp/blank), pend_valid flag, active set, state {GAP, SHOW}, cycle counter, digit index.
- iLoad=1: pending <= inputs, pend_valid <= 1. Repeated loads within a frame: last wins.
- Frame wrap = edge ending SHOW of digit DIGITS-1. At that edge: if iLoad=1, active <= live inputs directly and pend_valid <= 0; else if pend_valid, active <= pending and pend_valid <= 0; else active unchanged. oFrame = 1 the following cycle only.
- FSM: GAP holds GAP_CYC cycles, then SHOW. SHOW holds SHOW_CYC cycles, then GAP with index+1; index wraps DIGITS-1 -> 0.
- GAP: oAn all 1, oSeg = 7'h7F, oDp = 1.
- SHOW on digit k: oAn[k] = 0, others 1. Segments from active code k: 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10; HEX_EN=1: A=7'h08, b=7'h03, C=7'h46, d=7'h21, E=7'h06, F=7'h0E; HEX_EN=0: 10-15 -> 7'h7F. oDp = ~dp[k].
- Digit dark (oSeg=7'h7F, oDp=1, oAn[k] still 0) if blank[k]=1, or iLzs=1 and digit k is a leading zero: code 0 and all higher-index codes 0 (or blanked). Digit 0 never suppressed by iLzs; a lit dp does not prevent suppression.

## Timing
- All outputs registered; no combinational path from inputs to outputs.
- Reset (async, any time, mid-frame included): oSeg=7'h7F, oDp=1, oAn=all 1, oFrame=0, state=GAP, counter=0, index=0, active and pending all zero (display shows 0s), pend_valid=0. Output change is immediate on iRst_n low, not clock-aligned.
- After iRst_n release: first GAP_CYC edges keep all off; oAn[0] goes low after edge GAP_CYC and stays low exactly SHOW_CYC cycles.
- Per digit slot SHOW_CYC+GAP_CYC; frame DIGITS*(SHOW_CYC+GAP_CYC) cycles; oFrame period equals frame period.
- Load-to-display latency: ≤ 1 frame + GAP_CYC + 1 cycles; never mid-frame (no tearing).

## Test plan
Bench parameters DIGITS=4, SHOW_CYC=4, GAP_CYC=1, HEX_EN=1.
- Reset then run 2 frames -> oAn sequence 1111, 1110×4, 1111, 1101×4, 1111, 1011×4, 1111, 0111×4, repeat; oSeg=7'h40 during every SHOW; oFrame every 20 cycles.
- iLoad iData=16'h9A3F mid-frame -> current frame unchanged; next frame digit0..3 oSeg = 7'h0E, 7'h30, 7'h08, 7'h10; repeat with HEX_EN=0 -> digits 0 and 2 show 7'h7F.
- iData=16'h0050, iLzs=1 -> digits 3,2 dark, digit1=7'h12, digit0=7'h40; iData=16'h0000 -> only digit0 lit (7'h40).
- iDp=4'b0100, iBlank=4'b0001 -> oDp=0 only while oAn=1011; digit0 slot oSeg=7'h7F, oDp=1.
- iLoad exactly on frame-wrap edge with one pending earlier load -> live value displayed next frame, older pending discarded.
- Drop iRst_n mid-SHOW of digit 2 -> oAn=1111, oSeg=7'h7F immediately; after release, scan restarts at digit 0 showing 0.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - time-multiplexed N-digit 7-segment scan driver with frame-synchronous updates
module seg7_scan_driver #(
    parameter int DIGITS   = 8,
    parameter int SHOW_CYC = 50000,
    parameter int GAP_CYC  = 500,
    parameter int HEX_EN   = 1
) (
    input  logic                  iClk,
    input  logic                  iRst_n,
    input  logic [4*DIGITS-1:0]   iData,
    input  logic [DIGITS-1:0]     iDp,
    input  logic [DIGITS-1:0]     iBlank,
    input  logic                  iLoad,
    input  logic                  iLzs,
    output logic [6:0]            oSeg,
    output logic                  oDp,
    output logic [DIGITS-1:0]     oAn,
    output logic                  oFrame
);

    localparam int CNT_MAX = (SHOW_CYC > GAP_CYC) ? SHOW_CYC : GAP_CYC;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int IW      = $clog2(DIGITS);

    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYC - 1);
    localparam logic [CW-1:0] SHOW_LAST = CW'(SHOW_CYC - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

    typedef enum logic {S_GAP, S_SHOW} state_t;

    state_t                state, state_nxt;
    logic [CW-1:0]         cnt, cnt_nxt;
    logic [IW-1:0]         idx, idx_nxt;
    logic                  wrap;

    logic [4*DIGITS-1:0]   act_data, act_data_nxt, pend_data, pend_data_nxt;
    logic [DIGITS-1:0]     act_dp, act_dp_nxt, pend_dp, pend_dp_nxt;
    logic [DIGITS-1:0]     act_blank, act_blank_nxt, pend_blank, pend_blank_nxt;
    logic                  pend_valid, pend_valid_nxt;

    logic [6:0]            seg_nxt;
    logic                  dp_nxt;
    logic [DIGITS-1:0]     an_nxt;
    logic [3:0]            code;
    logic                  suppress;

    function automatic logic [6:0] decode(input logic [3:0] c);
        case (c)
            4'h0: decode = 7'h40;
            4'h1: decode = 7'h79;
            4'h2: decode = 7'h24;
            4'h3: decode = 7'h30;
            4'h4: decode = 7'h19;
            4'h5: decode = 7'h12;
            4'h6: decode = 7'h02;
            4'h7: decode = 7'h78;
            4'h8: decode = 7'h00;
            4'h9: decode = 7'h10;
            4'hA: decode = (HEX_EN != 0) ? 7'h08 : 7'h7F;
            4'hB: decode = (HEX_EN != 0) ? 7'h03 : 7'h7F;
            4'hC: decode = (HEX_EN != 0) ? 7'h46 : 7'h7F;
            4'hD: decode = (HEX_EN != 0) ? 7'h21 : 7'h7F;
            4'hE: decode = (HEX_EN != 0) ? 7'h06 : 7'h7F;
            default: decode = (HEX_EN != 0) ? 7'h0E : 7'h7F;
        endcase
    endfunction

    // Scan sequencer: GAP then SHOW per digit, wrap flagged on the last digit's SHOW end
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 1'b1;
        idx_nxt   = idx;
        wrap      = 1'b0;
        case (state)
            S_GAP: begin
                if (cnt == GAP_LAST) begin
                    state_nxt = S_SHOW;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                if (cnt == SHOW_LAST) begin
                    state_nxt = S_GAP;
                    cnt_nxt   = '0;
                    if (idx == IDX_LAST) begin
                        idx_nxt = '0;
                        wrap    = 1'b1;
                    end else begin
                        idx_nxt = idx + 1'b1;
                    end
                end
            end
        endcase
    end

    // Shadow registers: loads park in pending; active only changes at the frame wrap
    always_comb begin
        act_data_nxt   = act_data;
        act_dp_nxt     = act_dp;
        act_blank_nxt  = act_blank;
        pend_data_nxt  = pend_data;
        pend_dp_nxt    = pend_dp;
        pend_blank_nxt = pend_blank;
        pend_valid_nxt = pend_valid;
        if (wrap && iLoad) begin
            act_data_nxt   = iData;
            act_dp_nxt     = iDp;
            act_blank_nxt  = iBlank;
            pend_valid_nxt = 1'b0;
        end else if (wrap && pend_valid) begin
            act_data_nxt   = pend_data;
            act_dp_nxt     = pend_dp;
            act_blank_nxt  = pend_blank;
            pend_valid_nxt = 1'b0;
        end else if (iLoad) begin
            pend_data_nxt  = iData;
            pend_dp_nxt    = iDp;
            pend_blank_nxt = iBlank;
            pend_valid_nxt = 1'b1;
        end
    end

    // Output values for the cycle after this edge, so the pins are purely registered
    always_comb begin
        seg_nxt  = 7'h7F;
        dp_nxt   = 1'b1;
        an_nxt   = '1;
        code     = act_data_nxt[{idx_nxt, 2'b00} +: 4];
        suppress = iLzs && (idx_nxt != '0);
        for (int j = 0; j < DIGITS; j++) begin
            if ((IW'(j) >= idx_nxt) && (act_data_nxt[4*j +: 4] != 4'h0) && !act_blank_nxt[j])
                suppress = 1'b0;
        end
        if (state_nxt == S_SHOW) begin
            an_nxt[idx_nxt] = 1'b0;
            if (!act_blank_nxt[idx_nxt] && !suppress) begin
                seg_nxt = decode(code);
                dp_nxt  = ~act_dp_nxt[idx_nxt];
            end
        end
    end

    // Sequencer state registers
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state <= S_GAP;
            cnt   <= '0;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            idx   <= idx_nxt;
        end
    end

    // Active and pending digit sets
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            act_data   <= '0;
            act_dp     <= '0;
            act_blank  <= '0;
            pend_data  <= '0;
            pend_dp    <= '0;
            pend_blank <= '0;
            pend_valid <= 1'b0;
        end else begin
            act_data   <= act_data_nxt;
            act_dp     <= act_dp_nxt;
            act_blank  <= act_blank_nxt;
            pend_data  <= pend_data_nxt;
            pend_dp    <= pend_dp_nxt;
            pend_blank <= pend_blank_nxt;
            pend_valid <= pend_valid_nxt;
        end
    end

    // Registered display pins; reset blanks them immediately
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            oSeg   <= 7'h7F;
            oDp    <= 1'b1;
            oAn    <= '1;
            oFrame <= 1'b0;
        end else begin
            oSeg   <= seg_nxt;
            oDp    <= dp_nxt;
            oAn    <= an_nxt;
            oFrame <= wrap;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - directed self-checking bench for seg7_scan_driver
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] data;
    logic [3:0]  dp_in, blank;
    logic        load, lzs;
    logic [6:0]  seg, seg_n;
    logic        odp, odp_n, frame, frame_n;
    logic [3:0]  an, an_n;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    seg7_scan_driver #(.DIGITS(4), .SHOW_CYC(4), .GAP_CYC(1), .HEX_EN(1)) dut (
        .iClk(clk), .iRst_n(rst_n), .iData(data), .iDp(dp_in), .iBlank(blank),
        .iLoad(load), .iLzs(lzs), .oSeg(seg), .oDp(odp), .oAn(an), .oFrame(frame)
    );

    seg7_scan_driver #(.DIGITS(4), .SHOW_CYC(4), .GAP_CYC(1), .HEX_EN(0)) dut_nohex (
        .iClk(clk), .iRst_n(rst_n), .iData(data), .iDp(dp_in), .iBlank(blank),
        .iLoad(load), .iLzs(lzs), .oSeg(seg_n), .oDp(odp_n), .oAn(an_n), .oFrame(frame_n)
    );

    task automatic wait_frame();
        bit found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            load = 1'b0;
            if (frame === 1'b1) found = 1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL frame_timeout: no oFrame within 60 cycles, required a pulse every 20");
        end
    endtask

    task automatic grab_frame(output logic [27:0] s, output logic [27:0] sn, output logic [3:0] d);
        logic [3:0] exp_an;
        int k;
        s = '0; sn = '0; d = '0;
        wait_frame();
        for (int t = 1; t < 20; t++) begin
            @(negedge clk);
            if ((t - 1) % 5 == 0) begin
                k = (t - 1) / 5;
                s[7*k +: 7]  = seg;
                sn[7*k +: 7] = seg_n;
                d[k]         = odp;
                exp_an       = ~(4'b0001 << k);
                checks++;
                if (an !== exp_an) begin
                    errors++;
                    $display("FAIL an_slot digit %0d: got %b required %b", k, an, exp_an);
                end
            end
        end
    endtask

    task automatic do_load(input logic [15:0] dv, input logic [3:0] dpv, input logic [3:0] bv);
        @(negedge clk);
        data = dv; dp_in = dpv; blank = bv; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic check_frame(input string name, input logic [27:0] got, input logic [27:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; data = '0; dp_in = '0; blank = '0; load = 1'b0; lzs = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (seg !== 7'h7F || odp !== 1'b1 || an !== 4'hF || frame !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got seg=%h dp=%b an=%b frame=%b required 7f 1 1111 0", seg, odp, an, frame);
        end
    endtask

    task automatic test_scan();
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        logic       exp_fr;
        int m;
        rst_n = 1'b1;
        for (int t = 1; t <= 40; t++) begin
            @(negedge clk);
            m = (t - 1) % 5;
            if (m == 4) begin
                exp_an = 4'hF; exp_seg = 7'h7F;
            end else begin
                exp_an = ~(4'b0001 << (((t - 1) / 5) % 4)); exp_seg = 7'h40;
            end
            exp_fr = (t % 20 == 0);
            checks++;
            if (an !== exp_an || seg !== exp_seg || frame !== exp_fr) begin
                errors++;
                $display("FAIL scan t=%0d: got an=%b seg=%h frame=%b required %b %h %b", t, an, seg, frame, exp_an, exp_seg, exp_fr);
            end
        end
    endtask

    task automatic test_load_midframe();
        logic [27:0] s, sn;
        logic [3:0]  d;
        wait_frame();
        for (int t = 1; t < 20; t++) begin
            @(negedge clk);
            if (t == 7) begin
                data = 16'h9A3F; dp_in = '0; blank = '0; load = 1'b1;
            end
            if (t == 8) load = 1'b0;
            if (t == 11 || t == 16) begin
                checks++;
                if (seg !== 7'h40 || seg_n !== 7'h40) begin
                    errors++;
                    $display("FAIL no_tear t=%0d: got seg=%h seg_nohex=%h required 40", t, seg, seg_n);
                end
            end
        end
        grab_frame(s, sn, d);
        check_frame("hex_frame", s, {7'h10, 7'h08, 7'h30, 7'h0E});
        check_frame("nohex_frame", sn, {7'h10, 7'h7F, 7'h30, 7'h7F});
    endtask

    task automatic test_lzs();
        logic [27:0] s, sn;
        logic [3:0]  d;
        lzs = 1'b1;
        do_load(16'h0050, 4'b0000, 4'b0000);
        grab_frame(s, sn, d);
        check_frame("lzs_0050", s, {7'h7F, 7'h7F, 7'h12, 7'h40});
        do_load(16'h0000, 4'b0000, 4'b0000);
        grab_frame(s, sn, d);
        check_frame("lzs_0000", s, {7'h7F, 7'h7F, 7'h7F, 7'h40});
        lzs = 1'b0;
    endtask

    task automatic test_dp_blank();
        logic [27:0] s, sn;
        logic [3:0]  d;
        do_load(16'h1234, 4'b0100, 4'b0001);
        grab_frame(s, sn, d);
        check_frame("dp_blank_seg", s, {7'h79, 7'h24, 7'h30, 7'h7F});
        checks++;
        if (d !== 4'b1011) begin
            errors++;
            $display("FAIL dp_blank_dp: got %b required 1011", d);
        end
    endtask

    task automatic test_back_to_back();
        logic [27:0] s, sn;
        logic [3:0]  d;
        wait_frame();
        for (int t = 1; t < 20; t++) begin
            @(negedge clk);
            if (t == 3) begin
                data = 16'h8888; dp_in = '0; blank = '0; load = 1'b1;
            end
            if (t == 4) load = 1'b0;
            if (t == 19) begin
                data = 16'h4567; load = 1'b1;
            end
        end
        grab_frame(s, sn, d);
        check_frame("wrap_load", s, {7'h19, 7'h12, 7'h02, 7'h78});
        grab_frame(s, sn, d);
        check_frame("wrap_load_hold", s, {7'h19, 7'h12, 7'h02, 7'h78});
    endtask

    task automatic test_reset_mid();
        wait_frame();
        repeat (12) @(negedge clk);
        checks++;
        if (an !== 4'b1011) begin
            errors++;
            $display("FAIL pre_reset_an: got %b required 1011", an);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (an !== 4'hF || seg !== 7'h7F || odp !== 1'b1 || frame !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got an=%b seg=%h dp=%b frame=%b required 1111 7f 1 0", an, seg, odp, frame);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (an !== 4'b1110 || seg !== 7'h40 || odp !== 1'b1) begin
            errors++;
            $display("FAIL restart: got an=%b seg=%h dp=%b required 1110 40 1", an, seg, odp);
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_load_midframe();
        test_lzs();
        test_dp_blank();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
